// File: rtl/siso_sequencer_pkg.sv
// Shared encodings for the SISO sequencer: Johnson phase patterns and FSM states.
package siso_sequencer_pkg;

    localparam int PHASE_COUNT = 8;

    localparam logic [3:0] JOHN_PH0 = 4'b0000;
    localparam logic [3:0] JOHN_PH1 = 4'b0001;
    localparam logic [3:0] JOHN_PH2 = 4'b0011;
    localparam logic [3:0] JOHN_PH3 = 4'b0111;
    localparam logic [3:0] JOHN_PH4 = 4'b1111;
    localparam logic [3:0] JOHN_PH5 = 4'b1110;
    localparam logic [3:0] JOHN_PH6 = 4'b1100;
    localparam logic [3:0] JOHN_PH7 = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP1 = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/siso_sequencer_johnson_decode.sv
// 4-bit Johnson phase -> one-hot phase index; non-Johnson patterns raise illegal.
module siso_sequencer_johnson_decode
    import siso_sequencer_pkg::*;
(
    input  logic [3:0]             johnson,
    output logic [PHASE_COUNT-1:0] onehot,
    output logic                   illegal
);

    always_comb begin
        onehot  = '0;
        illegal = 1'b0;
        case (johnson)
            JOHN_PH0: onehot[0] = 1'b1;
            JOHN_PH1: onehot[1] = 1'b1;
            JOHN_PH2: onehot[2] = 1'b1;
            JOHN_PH3: onehot[3] = 1'b1;
            JOHN_PH4: onehot[4] = 1'b1;
            JOHN_PH5: onehot[5] = 1'b1;
            JOHN_PH6: onehot[6] = 1'b1;
            JOHN_PH7: onehot[7] = 1'b1;
            default:  illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/siso_sequencer.sv
// SISO sequencer: Johnson phase generation, run/step/halt control and
// self-check of SISO output against a delayed copy of its input.
module siso_sequencer
    import siso_sequencer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             CLR,
    input  logic             SHOW_LFSR,
    input  logic [7:0]       LFSR_STATE,
    input  logic             SISO_IN,
    input  logic             SISO_OUT,
    output logic [3:0]       JOHNSON,
    output logic [7:0]       PULSES,
    output logic [7:0]       BYTE_OUT,
    output logic             SHIFT,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             HALTED
);

    localparam int PRIME_W = $clog2(DEPTH + 1);
    localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(DEPTH);

    seq_state_t   state;
    logic         step_q;
    logic [DEPTH-1:0]   dline;
    logic [PRIME_W-1:0] prime;

    logic [PHASE_COUNT-1:0] cur_phase;
    logic       illegal;
    logic       advance;
    logic       step_rise;
    logic       mismatch;
    logic [3:0] johnson_next;
    logic [7:0] pulses_next;

    siso_sequencer_johnson_decode u_decode (
        .johnson (JOHNSON),
        .onehot  (cur_phase),
        .illegal (illegal)
    );

    // Next one-hot is the current one rotated; an illegal pattern restarts at phase 0.
    always_comb begin
        advance      = (state == ST_RUN) || (state == ST_STEP1);
        step_rise    = STEP & ~step_q;
        mismatch     = SHIFT && (prime == PRIME_FULL) && (SISO_OUT != dline[DEPTH-1]);
        johnson_next = illegal ? JOHN_PH0 : {JOHNSON[2:0], ~JOHNSON[3]};
        pulses_next  = illegal ? 8'h01 : {cur_phase[6:0], cur_phase[7]};
    end

    assign BYTE_OUT = SHOW_LFSR ? LFSR_STATE : PULSES;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            step_q  <= 1'b0;
            dline   <= '0;
            prime   <= '0;
            JOHNSON <= JOHN_PH0;
            PULSES  <= '0;
            SHIFT   <= 1'b0;
            ERR     <= 1'b0;
            ERR_CNT <= '0;
            HALTED  <= 1'b0;
        end else begin
            step_q <= STEP;
            PULSES <= '0;
            SHIFT  <= 1'b0;
            ERR    <= 1'b0;
            // CLR wins over everything and also suppresses this cycle's advance.
            if (CLR) begin
                state   <= ST_IDLE;
                HALTED  <= 1'b0;
                ERR_CNT <= '0;
                prime   <= '0;
                dline   <= '0;
            end else begin
                if (advance) begin
                    JOHNSON <= johnson_next;
                    PULSES  <= pulses_next;
                    SHIFT   <= cur_phase[7];
                end
                if (SHIFT) begin
                    dline <= {dline[DEPTH-2:0], SISO_IN};
                    if (prime != PRIME_FULL) prime <= prime + 1'b1;
                    if (mismatch) begin
                        ERR <= 1'b1;
                        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
                    end
                end
                case (state)
                    ST_IDLE: begin
                        if (RUN) state <= ST_RUN;
                        else if (step_rise) state <= ST_STEP1;
                    end
                    ST_RUN: begin
                        if (STOP_ON_ERR && mismatch) begin
                            state  <= ST_HALT;
                            HALTED <= 1'b1;
                        end else if (!RUN) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_STEP1: begin
                        if (STOP_ON_ERR && mismatch) begin
                            state  <= ST_HALT;
                            HALTED <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_siso_sequencer.sv
// Scoreboard bench: a phase-index reference model predicts every cycle for two
// sequencer instances (free-running with 4-bit counter, and stop-on-error).
module tb_siso_sequencer;

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
    localparam int REF_DEPTH = 8;

    typedef struct packed {
        int       mode;
        int       phase;
        int       prime;
        int       cnt;
        bit       stepprev;
        bit       shift;
        bit       err;
        bit       halted;
        bit [7:0] pulses;
        bit [7:0] hist;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst, run, step, clr, show, siso_in, siso_out;
    logic [7:0] lfsr;

    logic [3:0] a_john, b_john;
    logic [7:0] a_pulses, b_pulses, a_byte, b_byte;
    logic       a_shift, b_shift, a_err, b_err, a_halt, b_halt;
    logic [3:0] a_cnt;
    logic [7:0] b_cnt;

    int nchk = 0;
    int nerr = 0;

    bit [3:0] jtab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

    mstate_t ma, mb;
    mstate_t exp_a[$];
    mstate_t exp_b[$];
    bit [7:0] siso_sr = '0;
    int       siso_mode = 0;

    always #5 clk = ~clk;

    siso_sequencer #(.DEPTH(8), .ERR_W(4), .STOP_ON_ERR(1'b0)) dut_a (
        .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .CLR(clr),
        .SHOW_LFSR(show), .LFSR_STATE(lfsr), .SISO_IN(siso_in), .SISO_OUT(siso_out),
        .JOHNSON(a_john), .PULSES(a_pulses), .BYTE_OUT(a_byte), .SHIFT(a_shift),
        .ERR(a_err), .ERR_CNT(a_cnt), .HALTED(a_halt)
    );

    siso_sequencer #(.DEPTH(8), .ERR_W(8), .STOP_ON_ERR(1'b1)) dut_b (
        .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .CLR(clr),
        .SHOW_LFSR(show), .LFSR_STATE(lfsr), .SISO_IN(siso_in), .SISO_OUT(siso_out),
        .JOHNSON(b_john), .PULSES(b_pulses), .BYTE_OUT(b_byte), .SHIFT(b_shift),
        .ERR(b_err), .ERR_CNT(b_cnt), .HALTED(b_halt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of the reference: phase walks 0..7, a bit is shifted when leaving phase 7.
    function automatic mstate_t model_step(input mstate_t s, input bit stop, input int maxc);
        mstate_t n   = s;
        bit rise     = step && !s.stepprev;
        bit active   = (s.mode == M_RUN) || (s.mode == M_STEP);
        bit bad      = s.shift && (s.prime == REF_DEPTH) && (siso_out != s.hist[7]);
        n.stepprev = step;
        n.pulses   = '0;
        n.shift    = 1'b0;
        n.err      = 1'b0;
        if (clr) begin
            n.mode = M_IDLE; n.halted = 1'b0; n.cnt = 0; n.prime = 0; n.hist = '0;
        end else begin
            if (active) begin
                n.phase  = (s.phase + 1) % 8;
                n.pulses = 8'(1 << n.phase);
                n.shift  = (s.phase == 7);
            end
            if (s.shift) begin
                n.hist = {s.hist[6:0], siso_in};
                if (s.prime < REF_DEPTH) n.prime = s.prime + 1;
                if (bad) begin
                    n.err = 1'b1;
                    if (s.cnt < maxc) n.cnt = s.cnt + 1;
                end
            end
            case (s.mode)
                M_IDLE:  n.mode = run ? M_RUN : (rise ? M_STEP : M_IDLE);
                M_RUN:   n.mode = (stop && bad) ? M_HALT : (run ? M_RUN : M_IDLE);
                M_STEP:  n.mode = (stop && bad) ? M_HALT : M_IDLE;
                default: n.mode = M_HALT;
            endcase
            if (n.mode == M_HALT) n.halted = 1'b1;
        end
        return n;
    endfunction

    // Called at a falling edge with inputs set; predicts the next rising edge.
    task automatic cycle();
        mstate_t na, nb;
        case (siso_mode)
            0:       siso_out = siso_sr[7];
            1:       siso_out = 1'b1;
            default: siso_out = siso_sr[7] ^ ($urandom_range(0, 19) == 0);
        endcase
        na = model_step(ma, 1'b0, 15);
        nb = model_step(mb, 1'b1, 255);
        exp_a.push_back(na);
        exp_b.push_back(nb);
        if (ma.shift) siso_sr = {siso_sr[6:0], siso_in};
        ma = na;
        mb = nb;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (siso_mode != 1) siso_in = 1'($urandom);
            cycle();
        end
    endtask

    task automatic async_reset_check();
        rst = 1'b1;
        #1;
        chk("rst_a_johnson", a_john, 0);
        chk("rst_a_pulses", a_pulses, 0);
        chk("rst_a_shift", a_shift, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_halted", a_halt, 0);
        chk("rst_b_johnson", b_john, 0);
        chk("rst_b_cnt", b_cnt, 0);
        chk("rst_b_halted", b_halt, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ma  = '0;
        mb  = '0;
    endtask

    always @(posedge clk) begin
        mstate_t ea, eb;
        #1;
        if (!rst) begin
            if (exp_a.size() == 0 || exp_b.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_underflow actual=empty expected=entry at %0t", $time);
            end else begin
                ea = exp_a.pop_front();
                eb = exp_b.pop_front();
                chk("a_johnson", a_john, jtab[ea.phase]);
                chk("a_pulses", a_pulses, ea.pulses);
                chk("a_shift", a_shift, ea.shift);
                chk("a_err", a_err, ea.err);
                chk("a_err_cnt", a_cnt, ea.cnt);
                chk("a_halted", a_halt, ea.halted);
                chk("a_byte_out", a_byte, show ? lfsr : ea.pulses);
                chk("b_johnson", b_john, jtab[eb.phase]);
                chk("b_pulses", b_pulses, eb.pulses);
                chk("b_shift", b_shift, eb.shift);
                chk("b_err", b_err, eb.err);
                chk("b_err_cnt", b_cnt, eb.cnt);
                chk("b_halted", b_halt, eb.halted);
                chk("b_byte_out", b_byte, show ? lfsr : eb.pulses);
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; clr = 1'b0; show = 1'b0;
        lfsr = 8'h00; siso_in = 1'b0; siso_out = 1'b0;
        ma = '0;
        mb = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // free run: one cycle to enter RUN, then 16 advances
        run = 1'b1;
        cycles(17);
        async_reset_check();

        // three single steps with STEP held high
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cycles(5);
            step = 1'b0;
            cycles(3);
        end
        chk("step_johnson", a_john, 4'b0111);
        async_reset_check();

        // ideal SISO, random data, >100 shifts
        run = 1'b1;
        for (int i = 0; i < 820; i++) begin
            show = 1'($urandom);
            lfsr = 8'($urandom);
            cycles(1);
        end
        chk("ideal_err_cnt", a_cnt, 0);
        show = 1'b0;
        async_reset_check();

        // stuck-at-1 output: errors from the 9th shift, counter saturates, B halts
        siso_mode = 1;
        siso_in   = 1'b0;
        run       = 1'b1;
        cycles(215);
        chk("stuck_a_sat", a_cnt, 15);
        chk("stuck_b_halted", b_halt, 1);
        show = 1'b1;
        lfsr = 8'hA5;
        cycles(1);
        chk("byte_lfsr", a_byte, 8'hA5);
        show = 1'b0;
        #1;
        chk("byte_pulses", a_byte, ma.pulses);

        // CLR releases HALT and clears the counters; running resumes
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        siso_mode = 0;
        cycles(40);
        chk("clr_b_halted", b_halt, 0);
        chk("clr_b_cnt", b_cnt, 0);

        // random control and noisy SISO, with one asynchronous reset mid-run
        siso_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            if ($urandom_range(0, 3) == 0) step = ~step;
            clr  = ($urandom_range(0, 63) == 0);
            show = 1'($urandom);
            lfsr = 8'($urandom);
            if (i == 750) async_reset_check();
            cycles(1);
        end
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/siso_sequencer.md
Name: siso_sequencer

Overview:
Sequencer for the 8-stage hand-built SISO shift register. Drives its 4-bit Johnson phase counter and the 8 decoded phase pulses, runs free, single-steps or halts, and checks the SISO output against a delayed copy of its own input. It also selects what drives the byte output port: SISO pulses or LFSR state. It sits between the clock/reset/D_IN resynch logic and the SISO macro, next to LFSR8.

Parameters:
DEPTH, 8, SISO length in bits; also the depth of the expected-data delay line (2..16).
ERR_W, 8, width of the saturating error counter.
STOP_ON_ERR, 0, when 1 a mismatch forces the FSM to HALT.

Ports:
CLK  in  1  single clock (selected clock, CLK_OUT upstream)
RESET  in  1  asynchronous, active-high reset
RUN  in  1  level; 1 = free-running sequencing
STEP  in  1  level; each rising edge (sampled on CLK) = one phase advance while not RUN
CLR  in  1  synchronous clear of HALT, error counter and priming count
SHOW_LFSR  in  1  byte-output select
LFSR_STATE  in  8  LFSR8 state
SISO_IN  in  1  resynchronised serial data entering the SISO
SISO_OUT  in  1  serial data leaving the SISO
JOHNSON  out  4  phase counter to the SISO
PULSES  out  8  one-hot phase pulse to the SISO
BYTE_OUT  out  8  SHOW_LFSR ? LFSR_STATE : PULSES
SHIFT  out  1  one-cycle strobe, one bit shifted (phase 7->0)
ERR  out  1  one-cycle strobe on mismatch
ERR_CNT  out  ERR_W  saturating mismatch count
HALTED  out  1  FSM in HALT

Behaviour:
- Reset: JOHNSON=0000, PULSES=0, SHIFT=0, ERR=0, ERR_CNT=0, HALTED=0, FSM=IDLE, delay line=0, prime count=0, STEP edge register=0.
- FSM states: IDLE, RUN, STEP1, HALT.
  IDLE->RUN when RUN=1. IDLE->STEP1 on a STEP rising edge.
  RUN->IDLE when RUN=0. STEP1->IDLE unconditionally after 1 cycle.
  RUN/STEP1->HALT on ERR when STOP_ON_ERR=1.
  HALT->IDLE only on CLR. CLR has priority over every other transition.
- Advance = (FSM==RUN or FSM==STEP1). On advance, JOHNSON <= {JOHNSON[2:0], ~JOHNSON[3]}.
  Sequence: 0000,0001,0011,0111,1111,1110,1100,1000, wrapping to 0000. Phase index k = 0..7 in that order.
- Any illegal JOHNSON pattern is forced to 0000 on the next advance.
- PULSES: registered one-hot of the phase index; PULSES[k]=1 only in the cycle after an advance into phase k, otherwise 0.
- SHIFT: registered; 1 in the cycle after an advance from phase 7 to phase 0. It coincides with PULSES[0].
- On each SHIFT cycle:
  - Delay line shifts in SISO_IN.
  - The prime counter increments, saturating at DEPTH.
  - If prime==DEPTH before the increment, compare SISO_OUT with the delay-line tail.
  - On mismatch, ERR=1 for that cycle; ERR_CNT increments and saturates at all-ones.
- ERR has 1-cycle latency after SHIFT and is never asserted during priming.
- STEP rising edge while in RUN or HALT is ignored and not queued.
- Simultaneous RUN=1 and STEP edge in IDLE: RUN wins.
- CLR: ERR_CNT=0, prime=0, delay line=0, leaves JOHNSON unchanged, FSM->IDLE.
- BYTE_OUT is purely combinational from SHOW_LFSR, LFSR_STATE and PULSES. No other combinational input-to-output paths exist.
- RESET asserted mid-sequence returns everything to reset values immediately, asynchronously.

Decomposition:
- Shared package: Johnson phase encodings (8 constants), FSM state encodings, PHASE_COUNT=8.
- One natural sub-module: johnson_decode (4-bit Johnson -> 8-bit one-hot, plus illegal flag), reusable by the SISO model.
- Delay line, comparator, FSM and output mux stay in the top.

Test Plan:
- Reset, then RUN=1 for 16 cycles -> JOHNSON walks 0001..1000,0000 twice; PULSES one-hot 01,02,..,80; SHIFT at cycles 8 and 16; ERR_CNT=0.
- RUN=0, three STEP rising edges with STEP held high 5 cycles each -> exactly 3 advances, JOHNSON=0111.
- SISO modelled as an ideal 8-bit delay on SHIFT, LFSR-fed SISO_IN, 100 shifts -> ERR never asserted, ERR_CNT=0.
- SISO_OUT stuck at 1 with SISO_IN=0 -> first ERR on the 9th SHIFT; ERR_CNT=1, then increments per SHIFT. With ERR_W=4, saturates at 15.
- STOP_ON_ERR=1, inject one mismatch -> HALTED=1, JOHNSON frozen despite RUN=1; CLR -> IDLE, ERR_CNT=0, RUN resumes.
- SHOW_LFSR toggled with LFSR_STATE=8'hA5 -> BYTE_OUT=A5 / PULSES value. RESET pulsed mid-RUN -> all outputs 0 without waiting for a clock edge.
